// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store sequencer with RMW for sub-word stores
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic        accept;
  logic        req_misaligned;
  logic        subword_store;
  logic [31:0] word_addr;
  logic [4:0]  lane_shift;
  logic [31:0] lane_word;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merge_val;

  assign accept         = (state == S_IDLE) && req_valid;
  assign req_misaligned = (req_size == 2'b11) ||
                          ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign subword_store  = we_q && (size_q != 2'b10);
  assign word_addr      = {addr_q[31:2], 2'b00};
  assign lane_shift     = {addr_q[1:0], 3'b000};
  assign lane_word      = mem_rd >> lane_shift;

  // Load result: pick the addressed lane and sign/zero extend it
  always_comb begin
    load_val = mem_rd;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, lane_word[7:0]}
                                : {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, lane_word[15:0]}
                                : {{16{lane_word[15]}}, lane_word[15:0]};
      default: load_val = mem_rd;
    endcase
  end

  // Sub-word store merge: overlay the low byte/half of the store data onto the read word
  always_comb begin
    lane_mask = (size_q == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF;
    lane_data = wdata_q & lane_mask;
    merge_val = (mem_rd & ~(lane_mask << lane_shift)) | (lane_data << lane_shift);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; misaligned requests skip memory entirely
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = req_misaligned ? S_RESP : S_ACCESS;
      S_ACCESS: state_nxt = subword_store ? S_WRITE : S_RESP;
      S_WRITE:  state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state and captured registers only, never from req_*
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    case (state)
      S_IDLE: req_ready = 1'b1;
      S_ACCESS: begin
        mem_a = word_addr;
        if (we_q && (size_q == 2'b10)) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        mem_a  = word_addr;
        mem_wd = merge_q;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  // Request capture, load result and RMW merge registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_misaligned;
        // Error responses arrive next cycle, so clear the result now
        if (req_misaligned) rsp_rdata <= '0;
      end
      if (state == S_ACCESS) begin
        if (!we_q) begin
          rsp_rdata <= load_val;
        end else begin
          rsp_rdata <= '0;
          merge_q   <= merge_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, word write on the rising edge
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load: little-endian lane pick plus extension
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    int o;
    o = int'(off);
    b = w[8*o +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Reference store: replace the covered bytes of the old word
  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] off,
                                            input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (size == 2'd2)
        r[8*i +: 8] = wd[8*i +: 8];
      else if (size == 2'd0 && i == int'(off))
        r[8*i +: 8] = wd[7:0];
      else if (size == 2'd1 && (i / 2) == int'(off[1]))
        r[8*i +: 8] = wd[8*(i % 2) +: 8];
    end
    return r;
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic hold, output logic [31:0] rdata_o);
    logic        err;
    logic [31:0] exp_rd;
    logic [31:0] new_w;
    int          exp_lat;
    int          exp_wr;
    int          lat;
    int          wr;
    int          idx;
    int          waited;
    idx     = int'(addr[9:2]);
    err     = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    exp_rd  = (!err && !we) ? ref_load(ref_mem[idx], addr[1:0], size, uns) : 32'h0;
    new_w   = (!err && we) ? ref_store(ref_mem[idx], addr[1:0], size, wdata) : ref_mem[idx];
    exp_wr  = (!err && we) ? 1 : 0;
    exp_lat = err ? 1 : ((we && size != 2'd2) ? 3 : 2);

    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    lat = 0;
    wr  = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      check("busy_ready", 32'(req_ready), 32'd0);
      if (mem_we) begin
        wr++;
        check("wr_addr", mem_a, {addr[31:2], 2'b00});
        check("wr_data", mem_wd, new_w);
      end
      if (rsp_valid) begin
        lat = k;
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("rsp_rdata", rsp_rdata, exp_rd);
      end
    end
    req_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("write_count", wr, exp_wr);
    ref_mem[idx] = new_w;
    @(negedge clk);
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
    check("idle_we", 32'(mem_we), 32'd0);
    check("rdata_hold", rsp_rdata, exp_rd);
    check("back_idle", 32'(req_ready), 32'd1);
    check("mem_word", mem[idx], ref_mem[idx]);
    rdata_o = rsp_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    rst_n        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'h8765_43A1; ref_mem[16] = 32'h8765_43A1;
    mem[17] = 32'h1122_3344; ref_mem[17] = 32'h1122_3344;

    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads from a known word
    do_req(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 1'b0, rd); check("lb_40", rd, 32'hFFFF_FFA1);
    do_req(1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 1'b0, rd); check("lbu_40", rd, 32'h0000_00A1);
    do_req(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 1'b0, rd); check("lh_42", rd, 32'hFFFF_8765);
    do_req(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 1'b0, rd); check("lhu_42", rd, 32'h0000_8765);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, rd); check("lw_40", rd, 32'h8765_43A1);

    // Sub-word and word stores
    do_req(1'b1, 2'd0, 1'b0, 32'h47, 32'hFFFF_FF5A, 1'b0, rd); check("sb_47", mem[17], 32'h5A22_3344);
    do_req(1'b1, 2'd1, 1'b0, 32'h44, 32'h1234_BEEF, 1'b0, rd); check("sh_44", mem[17], 32'h5A22_BEEF);
    do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'hDEAD_BEEF, 1'b0, rd); check("sw_80", mem[32], 32'hDEAD_BEEF);
    check("sw_rdata", rd, 32'h0);

    // Errors
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 1'b0, rd); check("lw_42_err_rdata", rd, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, 1'b0, rd);
    do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'hFFFF_FFFF, 1'b0, rd);

    // req_valid held high through the whole transaction
    do_req(1'b1, 2'd0, 1'b0, 32'h49, 32'h0000_00C3, 1'b1, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 1'b1, rd);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023)), $urandom, 1'($urandom_range(0, 1)), rd);
    end

    // Reset during the write cycle of a byte store
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h119;
    req_wdata = ~ref_mem[70];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_access_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("rmw_write_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_mem_a", mem_a, 32'h0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("abort_mem_word", mem[70], ref_mem[70]);
    do_req(1'b0, 2'd2, 1'b0, 32'h118, 32'h0, 1'b0, rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
